// File: rtl/ifu_pkg.sv
// Shared definitions for the instruction fetch unit: state encoding,
// the reset-time instruction and the default boot address.
package ifu_pkg;

    localparam logic [1:0]  ST_REQ           = 2'd0;
    localparam logic [1:0]  ST_WAIT          = 2'd1;
    localparam logic [1:0]  ST_HOLD          = 2'd2;

    localparam logic [31:0] INST_NOP         = 32'h00000013;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h80000000;

    typedef enum logic [1:0] {
        S_REQ  = ST_REQ,
        S_WAIT = ST_WAIT,
        S_HOLD = ST_HOLD
    } ifu_state_e;

endpackage

// File: rtl/ifu.sv
// Instruction fetch unit: holds the PC, issues one fetch at a time, buffers
// the returned word for the decoder and handles redirects from execute.
// A redirect while a fetch is outstanding marks the in-flight word for drop.
module ifu
    import ifu_pkg::*;
#(
    parameter int                  DATA_LEN = 32,
    parameter logic [DATA_LEN-1:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic                clk,
    input  logic                rst,
    output logic                req_valid,
    input  logic                req_ready,
    output logic [DATA_LEN-1:0] req_addr,
    input  logic                resp_valid,
    input  logic [31:0]         resp_inst,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [31:0]         inst,
    output logic [DATA_LEN-1:0] PC,
    output logic [DATA_LEN-1:0] PC_S,
    input  logic                jump_valid,
    input  logic [DATA_LEN-1:0] jump_addr
);

    localparam logic [DATA_LEN-1:0] PC_STEP    = DATA_LEN'(4);
    localparam logic [DATA_LEN-1:0] ALIGN_MASK = ~DATA_LEN'(3);

    ifu_state_e          state, state_n;
    logic [DATA_LEN-1:0] pc, pc_n;
    logic                drop, drop_n;
    logic [31:0]         inst_r, inst_n;
    logic [DATA_LEN-1:0] pc_r, pc_r_n;
    logic [DATA_LEN-1:0] jump_target;

    // Redirect targets are always word aligned.
    assign jump_target = jump_addr & ALIGN_MASK;

    // Handshake outputs are suppressed during reset and on any redirect cycle.
    assign req_valid = !rst && (state == S_REQ)  && !jump_valid;
    assign out_valid = !rst && (state == S_HOLD) && !jump_valid;
    assign req_addr  = pc;
    assign inst      = inst_r;
    assign PC        = pc_r;
    assign PC_S      = pc_r + PC_STEP;

    // State and buffer registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= S_REQ;
            pc     <= RESET_PC;
            drop   <= 1'b0;
            inst_r <= INST_NOP;
            pc_r   <= RESET_PC;
        end else begin
            state  <= state_n;
            pc     <= pc_n;
            drop   <= drop_n;
            inst_r <= inst_n;
            pc_r   <= pc_r_n;
        end
    end

    // Next-state logic: fetch sequencing, redirect handling and stale-word drop.
    always_comb begin
        state_n = state;
        pc_n    = pc;
        drop_n  = drop;
        inst_n  = inst_r;
        pc_r_n  = pc_r;
        case (state)
            S_REQ: begin
                if (jump_valid) begin
                    pc_n = jump_target;
                end else if (req_ready) begin
                    state_n = S_WAIT;
                end else begin
                    state_n = S_REQ;
                end
            end
            S_WAIT: begin
                if (resp_valid) begin
                    if (drop || jump_valid) begin
                        drop_n  = 1'b0;
                        state_n = S_REQ;
                        if (jump_valid) begin
                            pc_n = jump_target;
                        end else begin
                            pc_n = pc;
                        end
                    end else begin
                        inst_n  = resp_inst;
                        pc_r_n  = pc;
                        state_n = S_HOLD;
                    end
                end else if (jump_valid) begin
                    pc_n   = jump_target;
                    drop_n = 1'b1;
                end else begin
                    state_n = S_WAIT;
                end
            end
            S_HOLD: begin
                if (jump_valid) begin
                    pc_n    = jump_target;
                    state_n = S_REQ;
                end else if (out_ready) begin
                    pc_n    = pc + PC_STEP;
                    state_n = S_REQ;
                end else begin
                    state_n = S_HOLD;
                end
            end
            default: begin
                state_n = S_REQ;
                drop_n  = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_ifu.sv
// Directed testbench for the instruction fetch unit.
module tb_ifu;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic        resp_valid;
    logic [31:0] resp_inst;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] inst;
    logic [31:0] PC;
    logic [31:0] PC_S;
    logic        jump_valid;
    logic [31:0] jump_addr;

    int checks = 0;
    int errors = 0;
    logic outstanding = 1'b0;

    ifu dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_addr   (req_addr),
        .resp_valid (resp_valid),
        .resp_inst  (resp_inst),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .inst       (inst),
        .PC         (PC),
        .PC_S       (PC_S),
        .jump_valid (jump_valid),
        .jump_addr  (jump_addr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Track whether a request is outstanding, from the bench's view of the handshake.
    always @(posedge clk) begin
        if (rst) outstanding <= 1'b0;
        else if (req_valid && req_ready) outstanding <= 1'b1;
        else if (resp_valid) outstanding <= 1'b0;
    end

    // Protocol monitor: a response with nothing outstanding is illegal stimulus.
    always @(negedge clk) begin
        if (!rst && resp_valid && !outstanding) begin
            $display("FAIL protocol resp_valid with no outstanding request at %0t", $time);
            errors++;
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b1; req_ready = 1'b0; resp_valid = 1'b0; resp_inst = 32'h0;
        out_ready = 1'b0; jump_valid = 1'b0; jump_addr = 32'h0;
        tick; tick;
        checks++; if (req_valid !== 1'b0) begin $display("FAIL rst_req_valid got %b exp 0", req_valid); errors++; end
        checks++; if (out_valid !== 1'b0) begin $display("FAIL rst_out_valid got %b exp 0", out_valid); errors++; end
        checks++; if (inst !== 32'h00000013) begin $display("FAIL rst_inst got %h exp 00000013", inst); errors++; end
        checks++; if (PC !== 32'h80000000) begin $display("FAIL rst_pc got %h exp 80000000", PC); errors++; end
        rst = 1'b0;
        #1;
        checks++; if (req_valid !== 1'b1) begin $display("FAIL first_req_valid got %b exp 1", req_valid); errors++; end
        checks++; if (req_addr !== 32'h80000000) begin $display("FAIL first_req_addr got %h exp 80000000", req_addr); errors++; end
    endtask

    task automatic test_basic_fetch;
        req_ready = 1'b1;
        #1;
        checks++; if (req_addr !== 32'h80000000) begin $display("FAIL basic_addr got %h exp 80000000", req_addr); errors++; end
        tick;
        req_ready = 1'b0; resp_valid = 1'b1; resp_inst = 32'h00500093;
        #1;
        checks++; if (out_valid !== 1'b0) begin $display("FAIL basic_early_out got %b exp 0", out_valid); errors++; end
        checks++; if (req_valid !== 1'b0) begin $display("FAIL basic_wait_req got %b exp 0", req_valid); errors++; end
        tick;
        resp_valid = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b1) begin $display("FAIL basic_out_valid got %b exp 1", out_valid); errors++; end
        checks++; if (inst !== 32'h00500093) begin $display("FAIL basic_inst got %h exp 00500093", inst); errors++; end
        checks++; if (PC !== 32'h80000000) begin $display("FAIL basic_pc got %h exp 80000000", PC); errors++; end
        checks++; if (PC_S !== 32'h80000004) begin $display("FAIL basic_pc_s got %h exp 80000004", PC_S); errors++; end
    endtask

    task automatic test_hold_stall;
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick;
            checks++; if (out_valid !== 1'b1 || inst !== 32'h00500093 || PC !== 32'h80000000 || req_valid !== 1'b0)
                begin $display("FAIL stall_%0d out_valid %b inst %h pc %h req_valid %b exp 1 00500093 80000000 0", i, out_valid, inst, PC, req_valid); errors++; end
        end
        out_ready = 1'b1;
        tick;
        out_ready = 1'b0;
        #1;
        checks++; if (req_valid !== 1'b1) begin $display("FAIL stall_next_req got %b exp 1", req_valid); errors++; end
        checks++; if (req_addr !== 32'h80000004) begin $display("FAIL stall_next_addr got %h exp 80000004", req_addr); errors++; end
        checks++; if (out_valid !== 1'b0) begin $display("FAIL stall_out_drop got %b exp 0", out_valid); errors++; end
    endtask

    task automatic test_jump_wait;
        req_ready = 1'b1;
        tick;
        req_ready = 1'b0; jump_valid = 1'b1; jump_addr = 32'h80000103;
        tick;
        jump_valid = 1'b0; resp_valid = 1'b1; resp_inst = 32'hDEADBEEF;
        #1;
        checks++; if (out_valid !== 1'b0) begin $display("FAIL jw_out_during_resp got %b exp 0", out_valid); errors++; end
        tick;
        resp_valid = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0) begin $display("FAIL jw_out_valid got %b exp 0", out_valid); errors++; end
        checks++; if (req_valid !== 1'b1) begin $display("FAIL jw_req_valid got %b exp 1", req_valid); errors++; end
        checks++; if (req_addr !== 32'h80000100) begin $display("FAIL jw_req_addr got %h exp 80000100", req_addr); errors++; end
        checks++; if (inst !== 32'h00500093) begin $display("FAIL jw_inst got %h exp 00500093", inst); errors++; end
    endtask

    task automatic test_back_to_back_jumps;
        req_ready = 1'b1;
        tick;
        req_ready = 1'b0; jump_valid = 1'b1; jump_addr = 32'h80000300;
        tick;
        jump_addr = 32'h80000305;
        tick;
        jump_valid = 1'b0;
        tick; tick;
        resp_valid = 1'b1; resp_inst = 32'h11111111;
        tick;
        resp_valid = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0) begin $display("FAIL b2b_out_valid got %b exp 0", out_valid); errors++; end
        checks++; if (req_addr !== 32'h80000304) begin $display("FAIL b2b_req_addr got %h exp 80000304", req_addr); errors++; end
    endtask

    task automatic test_jump_with_resp;
        req_ready = 1'b1;
        tick;
        req_ready = 1'b0; resp_valid = 1'b1; resp_inst = 32'h22222222;
        jump_valid = 1'b1; jump_addr = 32'h80000200;
        #1;
        checks++; if (out_valid !== 1'b0) begin $display("FAIL jr_out_valid got %b exp 0", out_valid); errors++; end
        tick;
        resp_valid = 1'b0; jump_valid = 1'b0;
        #1;
        checks++; if (req_valid !== 1'b1) begin $display("FAIL jr_req_valid got %b exp 1", req_valid); errors++; end
        checks++; if (req_addr !== 32'h80000200) begin $display("FAIL jr_req_addr got %h exp 80000200", req_addr); errors++; end
        checks++; if (inst !== 32'h00500093) begin $display("FAIL jr_inst got %h exp 00500093", inst); errors++; end
    endtask

    task automatic test_jump_in_hold;
        req_ready = 1'b1;
        tick;
        req_ready = 1'b0; resp_valid = 1'b1; resp_inst = 32'h00A00113;
        tick;
        resp_valid = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b1 || inst !== 32'h00A00113 || PC !== 32'h80000200)
            begin $display("FAIL jh_hold out_valid %b inst %h pc %h exp 1 00a00113 80000200", out_valid, inst, PC); errors++; end
        jump_valid = 1'b1; jump_addr = 32'h80000040; out_ready = 1'b1;
        #1;
        checks++; if (out_valid !== 1'b0) begin $display("FAIL jh_out_valid got %b exp 0", out_valid); errors++; end
        tick;
        jump_valid = 1'b0; out_ready = 1'b0;
        #1;
        checks++; if (req_addr !== 32'h80000040) begin $display("FAIL jh_req_addr got %h exp 80000040", req_addr); errors++; end
    endtask

    task automatic test_wrap;
        jump_valid = 1'b1; jump_addr = 32'hFFFFFFFE;
        #1;
        checks++; if (req_valid !== 1'b0) begin $display("FAIL wrap_req_on_jump got %b exp 0", req_valid); errors++; end
        tick;
        jump_valid = 1'b0; req_ready = 1'b1;
        #1;
        checks++; if (req_addr !== 32'hFFFFFFFC) begin $display("FAIL wrap_req_addr got %h exp fffffffc", req_addr); errors++; end
        tick;
        req_ready = 1'b0; resp_valid = 1'b1; resp_inst = 32'h00000517;
        tick;
        resp_valid = 1'b0;
        #1;
        checks++; if (PC_S !== 32'h00000000) begin $display("FAIL wrap_pc_s got %h exp 00000000", PC_S); errors++; end
        out_ready = 1'b1;
        tick;
        out_ready = 1'b0;
        #1;
        checks++; if (req_addr !== 32'h00000000) begin $display("FAIL wrap_next_addr got %h exp 00000000", req_addr); errors++; end
    endtask

    task automatic test_reset_mid_fetch;
        req_ready = 1'b1;
        tick;
        req_ready = 1'b0; rst = 1'b1;
        #1;
        checks++; if (req_valid !== 1'b0 || out_valid !== 1'b0)
            begin $display("FAIL rm_outputs req_valid %b out_valid %b exp 0 0", req_valid, out_valid); errors++; end
        tick;
        resp_valid = 1'b1; resp_inst = 32'hBADBAD00;
        tick;
        resp_valid = 1'b0; rst = 1'b0;
        #1;
        checks++; if (req_valid !== 1'b1 || req_addr !== 32'h80000000)
            begin $display("FAIL rm_first_req valid %b addr %h exp 1 80000000", req_valid, req_addr); errors++; end
        checks++; if (inst !== 32'h00000013) begin $display("FAIL rm_inst_nop got %h exp 00000013", inst); errors++; end
        req_ready = 1'b1;
        tick;
        req_ready = 1'b0;
        tick;
        checks++; if (inst !== 32'h00000013) begin $display("FAIL rm_inst_wait got %h exp 00000013", inst); errors++; end
        resp_valid = 1'b1; resp_inst = 32'h00000517;
        tick;
        resp_valid = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b1 || inst !== 32'h00000517 || PC !== 32'h80000000)
            begin $display("FAIL rm_refetch out_valid %b inst %h pc %h exp 1 00000517 80000000", out_valid, inst, PC); errors++; end
    endtask

    initial begin
        test_reset;
        test_basic_fetch;
        test_hold_stall;
        test_jump_wait;
        test_back_to_back_jumps;
        test_jump_with_resp;
        test_jump_in_hold;
        test_wrap;
        test_reset_mid_fetch;
        tick;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
